// File: rtl/game_flow_ctrl.sv
// Round/score sequencer for the two-player VGA game: countdown, play, point hold, game over.
// Optional pause support is compiled in with `define GAME_PAUSE_EN.
//
// state  | meaning
// IDLE   | no game, scores and timer cleared
// READY  | pre-round countdown, one step per tick
// PLAY   | round running, hits score, timer counts down
// POINT  | one-second hold after a point, timer frozen
// OVER   | game finished, winner latched
// PAUSED | round frozen (GAME_PAUSE_EN only)
module game_flow_ctrl #(
    parameter int TICK_DIV      = 100_000_000,
    parameter int COUNTDOWN_SEC = 3,
    parameter int ROUND_SEC     = 30,
    parameter int WIN_SCORE     = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       p0_hit,
    input  logic       p1_hit,
    input  logic       theme_btn,
    input  logic       pause,
    output logic [3:0] state,
    output logic [3:0] score0,
    output logic [3:0] score1,
    output logic [3:0] cnt0,
    output logic [3:0] cnt1,
    output logic [1:0] winner,
    output logic       theme_c
);

    localparam int             TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [3:0]     RND_TENS  = 4'(ROUND_SEC / 10);
    localparam logic [3:0]     RND_ONES  = 4'(ROUND_SEC % 10);
    localparam logic [3:0]     CD_ONES   = 4'(COUNTDOWN_SEC);
    localparam logic [3:0]     WIN       = 4'(WIN_SCORE);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_READY  = 4'd1,
        S_PLAY   = 4'd2,
        S_POINT  = 4'd3,
        S_OVER   = 4'd4,
        S_PAUSED = 4'd5
    } state_t;

    state_t        st_q;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          hit0;
    logic          hit1;
    logic [3:0]    score0_inc;
    logic [3:0]    score1_inc;
    logic [3:0]    score0_new;
    logic [3:0]    score1_new;
    logic [3:0]    dec_ones;
    logic [3:0]    dec_tens;
    logic          timer_one;
    logic          win_hit;

`ifndef GAME_PAUSE_EN
    logic pause_unused;
    assign pause_unused = pause;
`endif

    function automatic logic [1:0] win_code(input logic [3:0] a, input logic [3:0] b);
        if (a > b)
            return 2'b01;
        else if (b > a)
            return 2'b10;
        else
            return 2'b11;
    endfunction

    assign state = st_q;
    assign tick  = (tick_cnt == TICK_LAST);

    always_comb begin
        hit0       = p0_hit & ~p1_hit;
        hit1       = p1_hit & ~p0_hit;
        score0_inc = score0 + 4'd1;
        score1_inc = score1 + 4'd1;
        score0_new = hit0 ? score0_inc : score0;
        score1_new = hit1 ? score1_inc : score1;
        win_hit    = (hit0 && score0_inc == WIN) || (hit1 && score1_inc == WIN);
        timer_one  = (cnt1 == 4'd0) && (cnt0 == 4'd1);
        dec_ones   = cnt0;
        dec_tens   = cnt1;
        // BCD borrow; a timer already at 00 stays there
        if (cnt0 != 4'd0) begin
            dec_ones = cnt0 - 4'd1;
        end else if (cnt1 != 4'd0) begin
            dec_ones = 4'd9;
            dec_tens = cnt1 - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            theme_c <= 1'b0;
        end else if (theme_btn) begin
            theme_c <= ~theme_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q     <= S_IDLE;
            tick_cnt <= '0;
            score0   <= 4'd0;
            score1   <= 4'd0;
            cnt0     <= 4'd0;
            cnt1     <= 4'd0;
            winner   <= 2'b00;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            case (st_q)
                S_IDLE: begin
                    if (start) begin
                        st_q     <= S_READY;
                        tick_cnt <= '0;
                        score0   <= 4'd0;
                        score1   <= 4'd0;
                        cnt1     <= 4'd0;
                        cnt0     <= CD_ONES;
                        winner   <= 2'b00;
                    end
                end
                S_READY: begin
                    if (tick) begin
                        if (timer_one) begin
                            st_q <= S_PLAY;
                            cnt1 <= RND_TENS;
                            cnt0 <= RND_ONES;
                        end else begin
                            cnt1 <= dec_tens;
                            cnt0 <= dec_ones;
                        end
                    end
                end
                S_PLAY: begin
`ifdef GAME_PAUSE_EN
                    if (pause) begin
                        st_q     <= S_PAUSED;
                        tick_cnt <= tick_cnt;
                    end else
`endif
                    begin
                        score0 <= score0_new;
                        score1 <= score1_new;
                        if (tick) begin
                            cnt1 <= dec_tens;
                            cnt0 <= dec_ones;
                        end
                        // hit is applied before a same-cycle timeout ends the round
                        if (win_hit || (tick && timer_one)) begin
                            st_q     <= S_OVER;
                            tick_cnt <= '0;
                            winner   <= win_code(score0_new, score1_new);
                        end else if (hit0 || hit1) begin
                            st_q     <= S_POINT;
                            tick_cnt <= '0;
                        end
                    end
                end
                S_POINT: begin
                    if (tick)
                        st_q <= S_PLAY;
                end
                S_OVER: begin
                    if (start) begin
                        st_q     <= S_READY;
                        tick_cnt <= '0;
                        score0   <= 4'd0;
                        score1   <= 4'd0;
                        cnt1     <= 4'd0;
                        cnt0     <= CD_ONES;
                        winner   <= 2'b00;
                    end
                end
`ifdef GAME_PAUSE_EN
                S_PAUSED: begin
                    tick_cnt <= tick_cnt;
                    if (pause || start)
                        st_q <= S_PLAY;
                end
`endif
                default: begin
                    st_q     <= S_IDLE;
                    tick_cnt <= '0;
                    score0   <= 4'd0;
                    score1   <= 4'd0;
                    cnt0     <= 4'd0;
                    cnt1     <= 4'd0;
                    winner   <= 2'b00;
                end
            endcase
        end
    end

endmodule
